// File: rtl/poly_pkg.sv
// Shared constants and types for the polynomial fold/reduce datapath.
// Holds the default NTT parameters, the controller state encoding, the
// centred-lift threshold and the encodings of the power-of-two output
// modulus select.
package poly_pkg;

  localparam int IN_W_DEF  = 24;
  localparam int OUT_W_DEF = 13;
  localparam int P_DEF     = 12587009;
  localparam int N_DEF     = 509;

  // Coefficients strictly above this value represent negative numbers.
  localparam int LIFT_THR  = (P_DEF - 1) / 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FOLD = 2'd2
  } state_t;

  // poly_q encodings: the two top output bits are ANDed with these.
  localparam logic [1:0] Q2K = 2'b00;
  localparam logic [1:0] Q4K = 2'b01;
  localparam logic [1:0] Q8K = 2'b11;

endpackage

// File: rtl/poly_fold_reduce_coeff_lift.sv
// coeff_lift: combinational centred lift of an NTT coefficient.
//   x : IN_W-bit coefficient, nominally in [0, P-1]
//   y : OUT_W-bit two's complement of (x > (P-1)/2 ? x - P : x)
// Only the low OUT_W bits of the result are needed, so the subtraction of P
// is carried out on the low bits only; the full-width compare still decides
// whether the value is treated as negative. Inputs >= P are not range-checked.
module coeff_lift
  import poly_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int P     = P_DEF
) (
  input  logic [IN_W-1:0]  x,
  output logic [OUT_W-1:0] y
);

  localparam logic [IN_W-1:0]  THR  = IN_W'((P - 1) / 2);
  localparam logic [OUT_W-1:0] P_LO = OUT_W'(P);

  always_comb begin
    y = x[OUT_W-1:0];
    if (x > THR) begin
      y = x[OUT_W-1:0] - P_LO;
    end
  end

endmodule

// File: rtl/poly_fold_reduce.sv
// poly_fold_reduce: streams in the 2N product coefficients of one polynomial,
// stores the lifted lower half, then folds the upper half onto it (add for
// X^N-1, subtract for X^N+1) and emits N masked OUT_W-bit coefficients.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               begins a polynomial (IDLE only); latches poly_q, cyclic
//   poly_q, cyclic      modulus select mask and fold polarity
//   in_valid/in_ready   input handshake, in_data in index order 0..2N-1
//   out_valid/out_ready output handshake, out_data index 0..N-1, out_last on N-1
//   busy                controller not IDLE
//   done                one-cycle pulse after the out_last handshake
module poly_fold_reduce
  import poly_pkg::*;
#(
  parameter int IN_W   = IN_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int P      = P_DEF,
  parameter int N      = N_DEF,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        poly_q,
  input  logic              cyclic,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [1:0]         qsel_q, qsel_d;
  logic               cyclic_q, cyclic_d;
  logic               out_valid_q, out_valid_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic               done_q, done_d;

  logic [OUT_W-1:0]   fold_buf [N];
  logic [OUT_W-1:0]   lift_val;
  logic [OUT_W-1:0]   buf_val;
  logic [OUT_W-1:0]   sum_val;
  logic               buf_we;
  logic               last_idx;
  logic               in_fire;
  logic               out_fire;

  coeff_lift #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .P     (P)
  ) u_in_lift (
    .x (in_data),
    .y (lift_val)
  );

  assign buf_val   = fold_buf[idx_q];
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);

  // Next-state, handshake and datapath control. Once the out_last beat is
  // sitting in the output register no further input is taken, so a stray
  // in_valid cannot be folded into a coefficient that does not exist.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    qsel_d      = qsel_q;
    cyclic_d    = cyclic_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    buf_we      = 1'b0;
    in_ready    = 1'b0;
    in_fire     = 1'b0;
    out_fire    = out_valid_q && out_ready;
    last_idx    = (idx_q == ADDR_W'(N - 1));
    sum_val     = cyclic_q ? (buf_val + lift_val) : (buf_val - lift_val);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = LOAD;
          qsel_d   = poly_q;
          cyclic_d = cyclic;
          idx_d    = '0;
        end
      end

      LOAD: begin
        in_ready = 1'b1;
        in_fire  = in_valid;
        if (in_fire) begin
          buf_we = 1'b1;
          if (last_idx) begin
            idx_d   = '0;
            state_d = FOLD;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
      end

      FOLD: begin
        in_ready = !(out_valid_q && out_last_q) && (!out_valid_q || out_ready);
        in_fire  = in_valid && in_ready;
        if (out_fire) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
        if (in_fire) begin
          out_valid_d = 1'b1;
          out_data_d  = {sum_val[OUT_W-1:OUT_W-2] & qsel_q, sum_val[OUT_W-3:0]};
          out_last_d  = last_idx;
          idx_d       = last_idx ? '0 : idx_q + ADDR_W'(1);
        end
        if (out_fire && out_last_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and output registers; reset aborts any polynomial in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      qsel_q      <= Q2K;
      cyclic_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      qsel_q      <= qsel_d;
      cyclic_q    <= cyclic_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  // Lower-half storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      fold_buf[idx_q] <= lift_val;
    end
  end

endmodule
